// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, constants and helpers for the PS/2 device receiver
package ps2_pkg;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    REQ    = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    ACK    = 6'b100000
  } state_t;

  localparam logic [1:0] PH_LAST       = 2'd3;
  localparam int         PS2_DATA_BITS = 8;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic hit);
    return (hit && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/ps2_rx_sfifo.sv
// rtl/ps2_rx_sfifo.sv - synchronous FIFO holding received bytes; head reads 0 while empty
module ps2_rx_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_dev_rx_fifo.sv
// rtl/ps2_dev_rx_fifo.sv - PS/2 device-side host-to-device receiver with byte FIFO
// PS2_RX_ERR_STATS_EN adds saturating error counters with a clear input.
module ps2_dev_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DATA_TIMEOUT = 20,
  parameter int FIFO_DEPTH   = 4,
  parameter int AUTO_ARM     = 0
) (
  input  logic                          clock_quarter,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          ready,
  output logic                          busy,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          err_parity,
  output logic                          err_stop,
  output logic                          err_overflow,
  output logic                          err_timeout,
  output logic                          err_abort,
`ifdef PS2_RX_ERR_STATS_EN
  input  logic                          stats_clr,
  output logic [7:0]                    cnt_parity,
  output logic [7:0]                    cnt_stop,
  output logic [7:0]                    cnt_overflow,
  output logic [7:0]                    cnt_abort,
`endif
  inout  wire                           PS2_CLK,
  inout  wire                           PS2_DAT
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(DATA_TIMEOUT + 2);

  state_t          state, state_nx;
  logic            clk_s, dat_s;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      ph;
  logic [2:0]      bit_cnt;
  logic [TW-1:0]   wait_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            div_end, bit_end, inhibit, host_req, timeout;
  logic            frame_good, stop_end, push, pop, full, empty;

  assign ready      = (state == IDLE);
  assign busy       = state inside {DATA, PARITY, STOP, ACK};
  assign div_end    = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_end    = busy && (ph == PH_LAST) && div_end;
  assign inhibit    = bit_end && !clk_s && (state inside {DATA, PARITY, STOP});
  assign host_req   = clk_s && !dat_s;
  assign timeout    = (state == REQ) && !host_req && (wait_cnt > TW'(DATA_TIMEOUT));
  assign frame_good = (^{shreg, par_bit}) && dat_s;
  assign stop_end   = (state == STOP) && bit_end && !inhibit;
  assign push       = stop_end && frame_good;
  assign pop        = rx_valid && rx_ready;
  assign rx_valid   = !empty;

  // Open-drain pins: only ever pull low, decoded straight from state so reset releases them at once.
  assign PS2_CLK = (busy && (ph == 2'd1 || ph == 2'd2)) ? 1'b0 : 1'bz;
  assign PS2_DAT = ((state == ACK) && (ph != 2'd0)) ? 1'b0 : 1'bz;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if ((AUTO_ARM != 0) || start) state_nx = REQ;
      REQ:     if (host_req) state_nx = DATA;
               else if (timeout) state_nx = IDLE;
      DATA:    if (inhibit) state_nx = IDLE;
               else if (bit_end && bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nx = PARITY;
      PARITY:  if (inhibit) state_nx = IDLE;
               else if (bit_end) state_nx = STOP;
      STOP:    if (bit_end) state_nx = (!inhibit && frame_good) ? ACK : IDLE;
      ACK:     if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_quarter or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clk_s        <= 1'b1;
      dat_s        <= 1'b1;
      div_cnt      <= '0;
      ph           <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      err_parity   <= 1'b0;
      err_stop     <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      state <= state_nx;
      clk_s <= PS2_CLK;
      dat_s <= PS2_DAT;
      // Every exit from the busy states happens at bit_end, so ph wraps back to 0 on the way out.
      if (!busy) begin
        div_cnt <= '0;
        ph      <= '0;
      end else if (div_end) begin
        div_cnt <= '0;
        ph      <= ph + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      wait_cnt <= (state == REQ) ? wait_cnt + 1'b1 : '0;
      if (state != DATA)  bit_cnt <= '0;
      else if (bit_end)   bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && bit_end)   shreg   <= {dat_s, shreg[7:1]};
      if (state == PARITY && bit_end) par_bit <= dat_s;
      err_parity   <= stop_end && !(^{shreg, par_bit});
      err_stop     <= stop_end && !dat_s;
      err_overflow <= push && full && !pop;
      err_timeout  <= timeout;
      err_abort    <= inhibit;
    end
  end

  ps2_rx_sfifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock_quarter),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (rx_data),
    .full      (full),
    .empty     (empty),
    .level     (rx_level)
  );

`ifdef PS2_RX_ERR_STATS_EN
  always_ff @(posedge clock_quarter or negedge reset_n) begin
    if (!reset_n) begin
      cnt_parity   <= '0;
      cnt_stop     <= '0;
      cnt_overflow <= '0;
      cnt_abort    <= '0;
    end else if (stats_clr) begin
      cnt_parity   <= '0;
      cnt_stop     <= '0;
      cnt_overflow <= '0;
      cnt_abort    <= '0;
    end else begin
      cnt_parity   <= sat_inc(cnt_parity, err_parity);
      cnt_stop     <= sat_inc(cnt_stop, err_stop);
      cnt_overflow <= sat_inc(cnt_overflow, err_overflow);
      cnt_abort    <= sat_inc(cnt_abort, err_abort);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_dev_rx_fifo.sv
// tb/tb_ps2_dev_rx_fifo.sv - host-side frame driver with byte scoreboard and error-pulse tallies
module tb_ps2_dev_rx_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rx_ready = 1'b0;
  logic host_clk_low = 1'b0;
  logic host_dat_low = 1'b0;
  logic ready, busy, rx_valid;
  logic [7:0] rx_data;
  logic [$clog2(DEPTH):0] rx_level;
  logic err_parity, err_stop, err_overflow, err_timeout, err_abort;
`ifdef PS2_RX_ERR_STATS_EN
  logic stats_clr = 1'b0;
  logic [7:0] cnt_parity, cnt_stop, cnt_overflow, cnt_abort;
`endif
  wire ps2_clk;
  wire ps2_dat;

  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;
  pullup pu_clk (ps2_clk);
  pullup pu_dat (ps2_dat);

  always #5 clk = ~clk;

  ps2_dev_rx_fifo #(
    .CLK_DIV      (2),
    .DATA_TIMEOUT (TMO),
    .FIFO_DEPTH   (DEPTH),
    .AUTO_ARM     (0)
  ) dut (
    .clock_quarter (clk),
    .reset_n       (rst_n),
    .start         (start),
    .ready         (ready),
    .busy          (busy),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_level      (rx_level),
    .err_parity    (err_parity),
    .err_stop      (err_stop),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout),
    .err_abort     (err_abort),
`ifdef PS2_RX_ERR_STATS_EN
    .stats_clr     (stats_clr),
    .cnt_parity    (cnt_parity),
    .cnt_stop      (cnt_stop),
    .cnt_overflow  (cnt_overflow),
    .cnt_abort     (cnt_abort),
`endif
    .PS2_CLK       (ps2_clk),
    .PS2_DAT       (ps2_dat)
  );

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  int n_par = 0, n_stop = 0, n_ovf = 0, n_tmo = 0, n_abt = 0;
  int e_par = 0, e_stop = 0, e_ovf = 0, e_tmo = 0, e_abt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: tallies one-cycle error pulses and checks every popped byte against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      n_par  += int'(err_parity);
      n_stop += int'(err_stop);
      n_ovf  += int'(err_overflow);
      n_tmo  += int'(err_timeout);
      n_abt  += int'(err_abort);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got byte %0h, expected none", rx_data);
        end else begin
          check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // mode 0: full frame; mode 1: host inhibits at data bit at_bit; mode 2: reset at data bit at_bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int mode, input int at_bit);
    logic good, prev, ack_seen;
    int k, budget;
    good = (^{d, par}) && stp;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    host_dat_low = 1'b1;
    prev = 1'b1;
    k = 0;
    budget = 0;
    while (k < 10) begin
      @(negedge clk);
      budget++;
      if (budget > 300) begin
        check("frame_progress", k, 10);
        break;
      end
      if (prev && !ps2_clk) begin
        if (k < 8) host_dat_low = !d[k];
        else if (k == 8) host_dat_low = !par;
        else begin
          host_dat_low = !stp;
          if (good) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else e_ovf++;
          end else begin
            e_par  += int'(!(^{d, par}));
            e_stop += int'(!stp);
          end
        end
        if (mode == 2 && k == at_bit) begin
          host_dat_low = 1'b0;
          rst_n = 1'b0;
          #1;
          check("rst_clk_released", ps2_clk, 1);
          check("rst_dat_released", ps2_dat, 1);
          check("rst_valid", rx_valid, 0);
          check("rst_level", rx_level, 0);
          check("rst_ready", ready, 1);
          exp_q.delete();
          @(negedge clk) rst_n = 1'b1;
          return;
        end
        if (mode == 1 && k == at_bit) begin
          host_clk_low = 1'b1;
          e_abt++;
          break;
        end
        k++;
      end
      prev = ps2_clk;
    end
    ack_seen = 1'b0;
    budget = 0;
    while (budget < 300) begin
      @(negedge clk);
      budget++;
      if (!ps2_dat && !host_dat_low) ack_seen = 1'b1;
      if (ready) break;
    end
    check("ready_after_frame", ready, 1);
    if (mode == 0) check("ack", ack_seen, good);
    host_dat_low = 1'b0;
    host_clk_low = 1'b0;
    @(negedge clk);
    if (mode == 1) begin
      check("abort_pins_clk", ps2_clk, 1);
      check("abort_pins_dat", ps2_dat, 1);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    rx_ready = 1'b1;
    while ((exp_q.size() != 0 || rx_valid) && b < 100) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", rx_valid, 0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_n_par"}, n_par, e_par);
    check({tag, "_n_stop"}, n_stop, e_stop);
    check({tag, "_n_ovf"}, n_ovf, e_ovf);
    check({tag, "_n_tmo"}, n_tmo, e_tmo);
    check({tag, "_n_abt"}, n_abt, e_abt);
  endtask

  initial begin
    logic [7:0] first, d;
    logic p, s;
    int cyc;
    logic clk_driven;

    repeat (3) @(negedge clk);
    check("rst_ready0", ready, 1);
    check("rst_busy0", busy, 0);
    check("rst_valid0", rx_valid, 0);
    check("rst_level0", rx_level, 0);
    check("rst_data0", rx_data, 0);
    check("rst_errs0", {err_parity, err_stop, err_overflow, err_timeout, err_abort}, 0);
    check("rst_pins0", {ps2_clk, ps2_dat}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    rx_ready = 1'b0;
    send_frame(8'hA5, odd_par(8'hA5), 1'b1, 0, 0);
    check("t1_level", rx_level, 1);
    check("t1_valid", rx_valid, 1);
    check("t1_head", rx_data, 8'hA5);

    send_frame(8'h3C, ~odd_par(8'h3C), 1'b1, 0, 0);
    check("t2_level", rx_level, 1);
    check_errs("t2");
    drain();

    rx_ready = 1'b0;
    first = 8'(($urandom));
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? first : 8'($urandom);
      send_frame(d, odd_par(d), 1'b1, 0, 0);
    end
    check("t3_level", rx_level, DEPTH);
    check("t3_head", rx_data, first);
    check_errs("t3");
    drain();

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    clk_driven = 1'b0;
    while (!err_timeout && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!ps2_clk) clk_driven = 1'b1;
    end
    e_tmo++;
    check("t4_latency", cyc, TMO + 3);
    check("t4_ready", ready, 1);
    check("t4_clk_never_driven", clk_driven, 0);
    @(negedge clk);

    d = 8'($urandom);
    send_frame(d, odd_par(d), 1'b1, 1, 3);
    check("t5_level", rx_level, 0);
    check_errs("t5");

    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      s = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      rx_ready = ($urandom_range(0, 2) != 0);
      send_frame(d, p, s, 0, 0);
    end
    check_errs("rand");
    drain();

    rx_ready = 1'b0;
    send_frame(8'h11, odd_par(8'h11), 1'b1, 0, 0);
    send_frame(8'h22, odd_par(8'h22), 1'b1, 0, 0);
    check("t6_level_before", rx_level, 2);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 2, 2);
    @(negedge clk);
    check("t6_level_after", rx_level, 0);
    send_frame(8'hC3, odd_par(8'hC3), 1'b1, 0, 0);
    check("t6_head_after", rx_data, 8'hC3);
    drain();
    check_errs("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, checks);
    $fatal(1);
  end

endmodule
